// File: rtl/checkout_sequencer.sv
// checkout_sequencer
//   Clocked checkout flow around the item-check datapath. A scan key press
//   latches one item (UPC plus the decoder's Discounted/Stolen flags) and the
//   display and LEDs are driven from that latched copy. Tallies of accepted
//   items, discounted items and stolen items are kept. Each accepted clean
//   item starts a scan lockout of HOLD_CYCLES cycles. A stolen item raises a
//   sticky alarm that only the clear key releases.
//
// Ports
//   clk         system clock
//   reset_n     asynchronous active-low reset
//   scan_n      scan key, active-low, asynchronous to clk
//   clear_n     clear/acknowledge key, active-low, asynchronous to clk
//   upc         live {U,P,C} switches
//   mark        live Mark switch (consumed by the external item decoder)
//   disc_in     Discounted flag from the combinational item decoder
//   stolen_in   Stolen flag from the combinational item decoder
//   item_upc    latched UPC for the hex item decoder
//   item_valid  1 = item_upc is meaningful, 0 = blank display
//   disc_led    latched Discounted flag of the current item
//   alarm_led   sticky stolen alarm
//   busy        high in CAPTURE/HOLD/ALARM, scans are ignored
//   item_cnt    accepted scans (saturating)
//   disc_cnt    accepted scans with disc_in=1 (saturating)
//   alarm_cnt   accepted scans with stolen_in=1 (saturating)
module checkout_sequencer #(
    parameter int HOLD_CYCLES = 25_000_000,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             scan_n,
    input  logic             clear_n,
    input  logic [2:0]       upc,
    input  logic             mark,
    input  logic             disc_in,
    input  logic             stolen_in,
    output logic [2:0]       item_upc,
    output logic             item_valid,
    output logic             disc_led,
    output logic             alarm_led,
    output logic             busy,
    output logic [CNT_W-1:0] item_cnt,
    output logic [CNT_W-1:0] disc_cnt,
    output logic [CNT_W-1:0] alarm_cnt
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_CAPTURE = 2'd1;
    localparam logic [1:0] S_HOLD    = 2'd2;
    localparam logic [1:0] S_ALARM   = 2'd3;

    localparam int              TMR_W    = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(HOLD_CYCLES - 1);

    // Saturating increment: a tally at its maximum stays there.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        if (en && (v != {CNT_W{1'b1}}))
            return v + 1'b1;
        else
            return v;
    endfunction

    // Mark only matters to the external decoder that produces disc_in/stolen_in.
    logic unused_mark;
    assign unused_mark = mark;

    logic             scan_sync_p0, scan_sync_p1, scan_prev_p2;
    logic             clr_sync_p0,  clr_sync_p1,  clr_prev_p2;
    logic             scan_p, clear_p;
    logic [1:0]       state;
    logic [TMR_W-1:0] timer;
    logic             clr_pend;

    // Stage p0/p1: two-flop synchronizers, preset to "released"; p2 holds the
    // previous synchronized level for falling-edge detection.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            scan_sync_p0 <= 1'b1;
            scan_sync_p1 <= 1'b1;
            scan_prev_p2 <= 1'b1;
            clr_sync_p0  <= 1'b1;
            clr_sync_p1  <= 1'b1;
            clr_prev_p2  <= 1'b1;
        end else begin
            scan_sync_p0 <= scan_n;
            scan_sync_p1 <= scan_sync_p0;
            scan_prev_p2 <= scan_sync_p1;
            clr_sync_p0  <= clear_n;
            clr_sync_p1  <= clr_sync_p0;
            clr_prev_p2  <= clr_sync_p1;
        end
    end

    // One pulse per press, however long the key is held.
    assign scan_p  = scan_prev_p2 & ~scan_sync_p1;
    assign clear_p = clr_prev_p2  & ~clr_sync_p1;

    assign busy = (state != S_IDLE);

    // Checkout FSM, item latch and tallies.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            timer      <= '0;
            clr_pend   <= 1'b0;
            item_upc   <= 3'd0;
            item_valid <= 1'b0;
            disc_led   <= 1'b0;
            alarm_led  <= 1'b0;
            item_cnt   <= '0;
            disc_cnt   <= '0;
            alarm_cnt  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    // Clear wins over a simultaneous scan; the scan is dropped.
                    if (clear_p) begin
                        item_valid <= 1'b0;
                        disc_led   <= 1'b0;
                        item_cnt   <= '0;
                        disc_cnt   <= '0;
                        alarm_cnt  <= '0;
                        timer      <= '0;
                    end else if (scan_p) begin
                        state <= S_CAPTURE;
                    end
                end
                S_CAPTURE: begin
                    item_upc   <= upc;
                    item_valid <= 1'b1;
                    disc_led   <= disc_in;
                    item_cnt   <= sat_inc(item_cnt, 1'b1);
                    disc_cnt   <= sat_inc(disc_cnt, disc_in);
                    alarm_cnt  <= sat_inc(alarm_cnt, stolen_in);
                    // A clear arriving now is applied once the capture has landed.
                    clr_pend   <= clear_p;
                    if (stolen_in) begin
                        alarm_led <= 1'b1;
                        state     <= S_ALARM;
                    end else begin
                        timer <= TMR_LOAD;
                        state <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    clr_pend <= 1'b0;
                    if (clear_p || clr_pend) begin
                        item_valid <= 1'b0;
                        disc_led   <= 1'b0;
                        item_cnt   <= '0;
                        disc_cnt   <= '0;
                        alarm_cnt  <= '0;
                        timer      <= '0;
                        state      <= S_IDLE;
                    end else if (timer == '0) begin
                        state <= S_IDLE;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                S_ALARM: begin
                    clr_pend <= 1'b0;
                    if (clear_p || clr_pend) begin
                        alarm_led <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_checkout_sequencer.sv
// tb_checkout_sequencer
//   Directed bench for checkout_sequencer with HOLD_CYCLES=4, CNT_W=2.
//   A behavioural model tracks what the outputs must be from key-press events
//   and a remaining-hold count; a negedge process compares every cycle, and
//   hand-computed literals pin key points of the scenario.
module tb_checkout_sequencer;

    localparam int HOLD = 4;
    localparam int CW   = 2;
    localparam int MAXC = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          scan_n = 1'b1;
    logic          clear_n = 1'b1;
    logic [2:0]    upc = 3'd0;
    logic          mark = 1'b0;
    logic          disc_in = 1'b0;
    logic          stolen_in = 1'b0;
    logic [2:0]    item_upc;
    logic          item_valid, disc_led, alarm_led, busy;
    logic [CW-1:0] item_cnt, disc_cnt, alarm_cnt;

    int total = 0;
    int bad   = 0;

    checkout_sequencer #(.HOLD_CYCLES(HOLD), .CNT_W(CW)) dut (
        .clk(clk), .reset_n(reset_n), .scan_n(scan_n), .clear_n(clear_n),
        .upc(upc), .mark(mark), .disc_in(disc_in), .stolen_in(stolen_in),
        .item_upc(item_upc), .item_valid(item_valid), .disc_led(disc_led),
        .alarm_led(alarm_led), .busy(busy), .item_cnt(item_cnt),
        .disc_cnt(disc_cnt), .alarm_cnt(alarm_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    localparam int M_IDLE = 0, M_CAP = 1, M_HOLD = 2, M_ALARM = 3;
    int   m_mode = M_IDLE, m_left = 0;
    bit   m_def = 0, m_valid = 0, m_disc = 0, m_alarm = 0;
    int   m_upc = 0, m_ic = 0, m_dc = 0, m_ac = 0;
    // Key samples taken at the last three edges (index 0 = most recent).
    bit   sh0 = 1, sh1 = 1, sh2 = 1, ch0 = 1, ch1 = 1, ch2 = 1;

    // A press is acted on two edges after the key is first seen low.
    wire scan_ev = !sh1 && sh2;
    wire clr_ev  = !ch1 && ch2;

    function automatic int bump(input int v, input bit en);
        return (en && v < MAXC) ? v + 1 : v;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_mode <= M_IDLE; m_left <= 0; m_def <= 0;
            m_valid <= 0; m_disc <= 0; m_alarm <= 0; m_upc <= 0;
            m_ic <= 0; m_dc <= 0; m_ac <= 0;
            sh0 <= 1; sh1 <= 1; sh2 <= 1; ch0 <= 1; ch1 <= 1; ch2 <= 1;
        end else begin
            sh0 <= scan_n;  sh1 <= sh0; sh2 <= sh1;
            ch0 <= clear_n; ch1 <= ch0; ch2 <= ch1;
            case (m_mode)
                M_IDLE: begin
                    if (clr_ev) begin
                        m_valid <= 0; m_disc <= 0; m_ic <= 0; m_dc <= 0; m_ac <= 0;
                    end else if (scan_ev) begin
                        m_mode <= M_CAP;
                    end
                end
                M_CAP: begin
                    m_upc <= int'(upc); m_valid <= 1; m_disc <= disc_in;
                    m_ic <= bump(m_ic, 1'b1);
                    m_dc <= bump(m_dc, disc_in);
                    m_ac <= bump(m_ac, stolen_in);
                    m_def <= clr_ev;
                    if (stolen_in) begin
                        m_alarm <= 1; m_mode <= M_ALARM;
                    end else begin
                        m_left <= HOLD; m_mode <= M_HOLD;
                    end
                end
                M_HOLD: begin
                    m_def <= 0;
                    if (clr_ev || m_def) begin
                        m_valid <= 0; m_disc <= 0; m_ic <= 0; m_dc <= 0; m_ac <= 0;
                        m_mode <= M_IDLE;
                    end else begin
                        m_left <= m_left - 1;
                        if (m_left == 1) m_mode <= M_IDLE;
                    end
                end
                default: begin
                    m_def <= 0;
                    if (clr_ev || m_def) begin
                        m_alarm <= 0; m_mode <= M_IDLE;
                    end
                end
            endcase
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (reset_n) begin
            chk("model.item_upc",   int'(item_upc),   m_upc);
            chk("model.item_valid", int'(item_valid), int'(m_valid));
            chk("model.disc_led",   int'(disc_led),   int'(m_disc));
            chk("model.alarm_led",  int'(alarm_led),  int'(m_alarm));
            chk("model.busy",       int'(busy),       int'(m_mode != M_IDLE));
            chk("model.item_cnt",   int'(item_cnt),   m_ic);
            chk("model.disc_cnt",   int'(disc_cnt),   m_dc);
            chk("model.alarm_cnt",  int'(alarm_cnt),  m_ac);
        end
    end

    // ---------------- stimulus ----------------
    task automatic idle(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic press_scan(input int held);
        @(posedge clk); #2 scan_n = 1'b0;
        repeat (held) @(posedge clk);
        #2 scan_n = 1'b1;
    endtask

    task automatic press_clear(input int held);
        @(posedge clk); #2 clear_n = 1'b0;
        repeat (held) @(posedge clk);
        #2 clear_n = 1'b1;
    endtask

    initial begin
        // Reset, then idle.
        idle(3);
        #2 reset_n = 1'b1;
        idle(10);
        @(negedge clk);
        chk("rst.item_valid", int'(item_valid), 0);
        chk("rst.busy",       int'(busy),       0);
        chk("rst.item_cnt",   int'(item_cnt),   0);
        chk("rst.alarm_led",  int'(alarm_led),  0);

        // Held scan of a discounted item: one capture, latency and hold length.
        upc = 3'b101; disc_in = 1'b1; stolen_in = 1'b0;
        @(posedge clk); #2 scan_n = 1'b0;
        for (int j = 1; j <= 8; j++) begin
            @(posedge clk); @(negedge clk);
            if (j == 2) chk("lat.busy_e2", int'(busy), 0);
            if (j == 3) begin
                chk("lat.busy_e3", int'(busy), 1);
                chk("lat.cnt_e3",  int'(item_cnt), 0);
            end
            if (j == 4) chk("lat.cnt_e4", int'(item_cnt), 1);
            if (j == 7) chk("lat.busy_e7", int'(busy), 1);
            if (j == 8) chk("lat.busy_e8", int'(busy), 0);
        end
        idle(12);
        #2 scan_n = 1'b1;
        idle(6);
        @(negedge clk);
        chk("held.item_upc",   int'(item_upc),   5);
        chk("held.item_valid", int'(item_valid), 1);
        chk("held.disc_led",   int'(disc_led),   1);
        chk("held.item_cnt",   int'(item_cnt),   1);
        chk("held.disc_cnt",   int'(disc_cnt),   1);

        // Second press lands in HOLD and is dropped; a later press is taken.
        press_clear(2); idle(6);
        upc = 3'b011; disc_in = 1'b0;
        @(posedge clk); #2 scan_n = 1'b0;
        @(posedge clk); #2 scan_n = 1'b1;
        @(posedge clk); #2 scan_n = 1'b0;
        idle(2); #2 scan_n = 1'b1;
        idle(12);
        @(negedge clk);
        chk("hold.item_cnt_drop", int'(item_cnt), 1);
        press_scan(2); idle(12);
        @(negedge clk);
        chk("hold.item_cnt_next", int'(item_cnt), 2);
        chk("hold.item_upc",      int'(item_upc), 3);

        // Stolen item: sticky alarm, scans ignored, clear releases.
        upc = 3'b010; stolen_in = 1'b1;
        press_scan(2); idle(10);
        @(negedge clk);
        chk("alarm.led",       int'(alarm_led), 1);
        chk("alarm.alarm_cnt", int'(alarm_cnt), 1);
        chk("alarm.busy",      int'(busy),      1);
        press_scan(2); idle(10);
        @(negedge clk);
        chk("alarm.scan_ign",  int'(item_cnt),  3);
        stolen_in = 1'b0;
        press_clear(2); idle(6);
        @(negedge clk);
        chk("alarm.led_off",   int'(alarm_led), 0);
        chk("alarm.cnt_kept",  int'(item_cnt),  3);
        chk("alarm.acnt_kept", int'(alarm_cnt), 1);
        chk("alarm.upc_kept",  int'(item_upc),  2);

        // Five clean scans saturate the item tally, then clear in IDLE.
        press_clear(2); idle(6);
        for (int i = 0; i < 5; i++) begin
            upc = 3'(i);
            press_scan(2); idle(10);
        end
        @(negedge clk);
        chk("sat.item_cnt",  int'(item_cnt),  3);
        chk("sat.alarm_cnt", int'(alarm_cnt), 0);
        chk("sat.item_upc",  int'(item_upc),  4);
        press_clear(2); idle(6);
        @(negedge clk);
        chk("clr.item_cnt",   int'(item_cnt),   0);
        chk("clr.item_valid", int'(item_valid), 0);

        // Scan and clear together in IDLE: clear wins.
        @(posedge clk); #2 scan_n = 1'b0; clear_n = 1'b0;
        idle(3); #2 scan_n = 1'b1; clear_n = 1'b1;
        idle(10);
        @(negedge clk);
        chk("both.item_cnt",   int'(item_cnt),   0);
        chk("both.item_valid", int'(item_valid), 0);

        // Clear pressed so it arrives during CAPTURE: capture lands, then clear.
        upc = 3'b110; disc_in = 1'b1;
        @(posedge clk); #2 scan_n = 1'b0;
        @(posedge clk); #2 clear_n = 1'b0;
        idle(3);
        @(negedge clk);
        chk("defer.captured", int'(item_cnt), 1);
        @(posedge clk); @(negedge clk);
        chk("defer.cleared",  int'(item_cnt),   0);
        chk("defer.valid",    int'(item_valid), 0);
        chk("defer.busy",     int'(busy),       0);
        #1 scan_n = 1'b1; clear_n = 1'b1;
        idle(8);

        // Reset pulse mid-HOLD.
        press_scan(1);
        idle(4);
        #2 reset_n = 1'b0;
        #1;
        chk("rstmid.item_cnt",   int'(item_cnt),   0);
        chk("rstmid.item_valid", int'(item_valid), 0);
        chk("rstmid.disc_led",   int'(disc_led),   0);
        chk("rstmid.busy",       int'(busy),       0);
        idle(2); #2 reset_n = 1'b1;
        idle(5);
        @(negedge clk);
        chk("rstmid.after_busy", int'(busy),     0);
        chk("rstmid.after_cnt",  int'(item_cnt), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Bound on the whole run.
    initial begin
        #200000;
        $display("FAIL timeout: run did not complete, total=%0d", total);
        $fatal(1, "timeout");
    end

endmodule
